// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   WORD_W / REG_W : data word width and register index width
//   word_t         : one data word
//   regbits_t      : one register index
//   wbq_entry_t    : one pending writeback (destination index + data)
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef struct packed {
        regbits_t sel;
        word_t    dat;
    } wbq_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Writeback request handshake into the register file writeback queue.
//   req_valid : request present (producer -> queue)
//   req_ready : queue accepts a request this cycle (queue -> producer)
//   req_sel   : destination register index
//   req_dat   : write data
// Modports: master = producer side, slave = queue side.
interface regfile_writeback_queue_if;
    import cpu_types_pkg::*;

    logic     req_valid;
    logic     req_ready;
    regbits_t req_sel;
    word_t    req_dat;

    modport master (
        output req_valid,
        output req_sel,
        output req_dat,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        input  req_dat,
        output req_ready
    );

endinterface

// File: rtl/wbq_fwd_mux.sv
// Read-port forwarding mux for the writeback queue (built only with WBQ_FORWARD_EN).
// Returns the data of the youngest valid queue entry whose index matches rd_sel_i,
// otherwise the raw register file data; register 0 always reads as zero.
//   entries_i : queue storage array
//   valid_i   : per-slot valid bits
//   head_i    : slot index of the oldest entry
//   rd_sel_i  : read index presented by the datapath
//   rf_rdat_i : raw register file read data
//   rd_dat_o  : coherent read data
`ifdef WBQ_FORWARD_EN
module wbq_fwd_mux
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wbq_entry_t                 entries_i [DEPTH],
    input  logic [DEPTH-1:0]           valid_i,
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  regbits_t                   rd_sel_i,
    input  word_t                      rf_rdat_i,
    output word_t                      rd_dat_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        idx      = '0;
        rd_dat_o = rf_rdat_i;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (valid_i[idx] && (entries_i[idx].sel == rd_sel_i)) begin
                rd_dat_o = entries_i[idx].dat;
            end
        end
        if (rd_sel_i == '0) begin
            rd_dat_o = '0;
        end
    end

endmodule
`endif

// File: rtl/regfile_writeback_queue.sv
// Register file writeback queue: buffers register writes in a FIFO and drains them
// into the register file write port whenever the port is free. Writes to register 0
// are accepted and dropped. Optional read forwarding (macro WBQ_FORWARD_EN) makes
// the read ports see pending writes; without it reads pass straight through.
//   clk, rst          : clock, asynchronous active-high reset
//   req               : request handshake (slave modport)
//   rf_busy           : register file write port unavailable this cycle
//   rf_WEN/wsel/wdat  : register file write port
//   rd_sel1/2         : datapath read indices
//   rf_rdat1/2        : raw register file read data
//   rd_dat1/2         : coherent read data
//   count/full/empty  : occupancy
// DEPTH must be a power of two and at least 2.
module regfile_writeback_queue
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    regfile_writeback_queue_if.slave   req,
    input  logic                       rf_busy,
    output logic                       rf_WEN,
    output regbits_t                   rf_wsel,
    output word_t                      rf_wdat,
    input  regbits_t                   rd_sel1,
    input  regbits_t                   rd_sel2,
    input  word_t                      rf_rdat1,
    input  word_t                      rf_rdat2,
    output word_t                      rd_dat1,
    output word_t                      rd_dat2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned      PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    wbq_entry_t       mem_q [DEPTH];
    wbq_entry_t       mem_d [DEPTH];

    logic       push;
    logic       enq;
    logic       deq;
    wbq_entry_t head;

    assign full          = (count_q == DEPTH_CNT);
    assign empty         = (count_q == '0);
    assign count         = count_q;
    // Depends only on state, so no combinational path from req_valid.
    assign req.req_ready = !full;

    assign push = req.req_valid && req.req_ready;
    assign enq  = push && (req.req_sel != '0);
    assign head = mem_q[rd_ptr_q];

    // Storage is unreset, so the write port is forced to zero while empty.
    assign rf_WEN  = !empty && !rf_busy;
    assign rf_wsel = empty ? '0 : head.sel;
    assign rf_wdat = empty ? '0 : head.dat;
    assign deq     = rf_WEN;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (enq) begin
            mem_d[wr_ptr_q] = '{sel: req.req_sel, dat: req.req_dat};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef WBQ_FORWARD_EN
    logic [DEPTH-1:0] valid_q, valid_d;

    // A slot becomes visible to forwarding only after the edge that fills it.
    always_comb begin
        valid_d = valid_q;
        if (deq) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (enq) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    wbq_fwd_mux #(
        .DEPTH (DEPTH)
    ) u_fwd_mux1 (
        .entries_i (mem_q),
        .valid_i   (valid_q),
        .head_i    (rd_ptr_q),
        .rd_sel_i  (rd_sel1),
        .rf_rdat_i (rf_rdat1),
        .rd_dat_o  (rd_dat1)
    );

    wbq_fwd_mux #(
        .DEPTH (DEPTH)
    ) u_fwd_mux2 (
        .entries_i (mem_q),
        .valid_i   (valid_q),
        .head_i    (rd_ptr_q),
        .rd_sel_i  (rd_sel2),
        .rf_rdat_i (rf_rdat2),
        .rd_dat_o  (rd_dat2)
    );
`else
    // Caller stalls on pending writes; read indices are not needed here.
    logic unused_rd_sel;
    assign unused_rd_sel = ^{rd_sel1, rd_sel2};
    assign rd_dat1       = rf_rdat1;
    assign rd_dat2       = rf_rdat2;
`endif

endmodule

// File: doc/regfile_writeback_queue.md
REGFILE_WRITEBACK_QUEUE -- requirements
Module: regfile_writeback_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of pending write entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; everything is sampled on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1, meaning a writeback request is present.
REQ-005 The block SHALL have port req_ready, output, 1, meaning the queue accepts a request this cycle.
REQ-006 The block SHALL have port req_sel, input, 5, meaning the destination register index.
REQ-007 The block SHALL have port req_dat, input, 32, meaning the write data.
REQ-008 The block SHALL have port rf_busy, input, 1, meaning the register file write port is unavailable this cycle.
REQ-009 The block SHALL have ports rf_WEN (output, 1), rf_wsel (output, 5) and rf_wdat (output, 32), driving the register file write port.
REQ-010 The block SHALL have ports rd_sel1 and rd_sel2 (input, 5 each), meaning the read indices the datapath presents.
REQ-011 The block SHALL have ports rf_rdat1 and rf_rdat2 (input, 32 each), meaning the raw register file read data.
REQ-012 The block SHALL have ports rd_dat1 and rd_dat2 (output, 32 each), meaning the coherent read data.
REQ-013 The block SHALL have ports count (output, clog2(DEPTH)+1), full (output, 1) and empty (output, 1), reporting occupancy.

Function
REQ-014 A request SHALL be accepted when req_valid and req_ready are both high at the rising edge; req_ready SHALL equal !full, with no combinational path from req_valid.
REQ-015 An accepted request with req_sel==0 SHALL be discarded and not enqueued; count SHALL stay unchanged.
REQ-016 rf_WEN SHALL equal !empty && !rf_busy, and rf_wsel and rf_wdat SHALL come from the head entry.
REQ-017 When rf_WEN is high at an edge, the head entry SHALL be dequeued.
REQ-018 Entries SHALL drain strictly in FIFO order, one per cycle at most.
REQ-019 Latency SHALL be as follows: a request accepted at edge N into an empty queue SHALL appear on rf_WEN during cycle N+1 if rf_busy is low.
REQ-020 On a simultaneous enqueue and dequeue, count SHALL be unchanged and both operations SHALL take effect.
REQ-021 When full, an enqueue SHALL occur only after space is freed, with ready low that cycle; a same-cycle dequeue SHALL NOT raise req_ready.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; full SHALL be count==DEPTH and empty SHALL be count==0.
REQ-023 rd_datN SHALL be the data of the youngest valid queue entry whose sel equals rd_selN, otherwise rf_rdatN.
REQ-024 rd_datN SHALL be 0 when rd_selN==0.
REQ-025 Forwarding SHALL include the head entry being written this cycle.
REQ-026 An entry being enqueued this cycle SHALL NOT be forwarded until the following cycle.
REQ-027 rf_busy held high SHALL stall the drain indefinitely; the contents SHALL be retained and enqueueing SHALL continue until full.

Reset
REQ-028 While rst is high, the pointers SHALL be 0 and count SHALL be 0.
REQ-029 While rst is high, empty SHALL be 1, full SHALL be 0, req_ready SHALL be 1, rf_WEN SHALL be 0, and rf_wsel and rf_wdat SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard all pending entries immediately, and no write SHALL issue while rst is high.
REQ-031 Entry data storage SHALL need no reset; only valid state and pointers are reset.

Configuration
REQ-032 With macro WBQ_FORWARD_EN defined, the forwarding of REQ-023 to REQ-026 SHALL be built.
REQ-033 Without WBQ_FORWARD_EN, rd_datN SHALL equal rf_rdatN directly, and the caller is responsible for stalling on pending writes.

Structure
REQ-034 The shared package cpu_types_pkg SHALL hold WORD_W=32, REG_W=5, word_t, regbits_t, and the packed struct wbq_entry_t {regbits_t sel; word_t dat;}.
REQ-035 Forwarding SHALL be one sub-module, wbq_fwd_mux, instantiated twice (once per read port), combinational and taking the entry array, valid bits and head pointer; it SHALL be omitted without WBQ_FORWARD_EN.

Verification
REQ-036 Scenario 1: enqueue sel=3, dat=0xDEADBEEF into an empty queue with rf_busy=0 -> the next cycle shows rf_WEN=1, rf_wsel=3, rf_wdat=0xDEADBEEF, and the cycle after shows empty=1.
REQ-037 Scenario 2: rf_busy=1, enqueue 5 requests with DEPTH=4 -> full=1 and req_ready=0 after 4; the 5th is held; with rf_busy=0, 4 writes issue in order, then the 5th.
REQ-038 Scenario 3: enqueue sel=0, dat=0x1234 -> count stays 0 and rf_WEN never rises.
REQ-039 Scenario 4: with WBQ_FORWARD_EN, rf_busy=1, enqueue sel=7 dat=0xA then sel=7 dat=0xB, rd_sel1=7, rf_rdat1=0x55 -> rd_dat1=0xB.
REQ-040 Scenario 5: with rd_sel2=0 and rf_rdat2=0xFFFF -> rd_dat2=0.
REQ-041 Scenario 6: 3 entries pending, assert rst mid-cycle -> count=0, rf_WEN=0 and empty=1 immediately; after release, no stale write issues.
